// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian byte program into instruction RAM, then releases the core.
// One byte per cycle in LEN/DATA; BYTE_READY drops for the single WRITE cycle after each word (5 cycles/word).
module imem_loader #(
    parameter int MAX_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [7:0]  BYTE_IN,
    input  logic        BYTE_VALID,
    output logic        BYTE_READY,
    input  logic [31:0] DIR_IMEM,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] IMEM_WDATA,
    output logic        IMEM_WE,
    output logic        CORE_RESET_N,
    output logic        DONE,
    output logic        ERROR
);

    localparam int IDX_W = $clog2(MAX_WORDS) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        RUN,
        ERR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         byte_cnt;
    logic [IDX_W-1:0]   word_idx;
    logic [IDX_W-1:0]   idx_inc;
    logic [31:0]        len_reg;
    logic [31:0]        word_reg;
    logic [31:0]        len_full;
    logic               byte_acc;
    logic               last_byte;
    logic               start_load;
    logic               last_word;

    assign byte_acc   = BYTE_READY & BYTE_VALID;
    assign last_byte  = byte_acc && (byte_cnt == 2'd3);
    // Little-endian shift-in: after four bytes the first byte sits in [7:0].
    assign len_full   = {BYTE_IN, len_reg[31:8]};
    assign idx_inc    = word_idx + IDX_W'(1);
    assign last_word  = (32'(idx_inc) == len_reg);
    assign start_load = START && (state == IDLE || state == RUN || state == ERR);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (START) state_nxt = LEN;
            LEN: begin
                if (last_byte) begin
                    if (len_full == 32'd0)                  state_nxt = RUN;
                    else if (len_full > 32'(MAX_WORDS))     state_nxt = ERR;
                    else                                    state_nxt = DATA;
                end
            end
            DATA:  if (last_byte) state_nxt = WRITE;
            WRITE: state_nxt = last_word ? RUN : DATA;
            RUN:   if (START) state_nxt = LEN;
            ERR:   if (START) state_nxt = LEN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            byte_cnt <= '0;
            word_idx <= '0;
            len_reg  <= '0;
            word_reg <= '0;
        end else if (start_load) begin
            byte_cnt <= '0;
            word_idx <= '0;
            len_reg  <= '0;
        end else begin
            if (byte_acc) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (state == LEN) len_reg  <= len_full;
                else              word_reg <= {BYTE_IN, word_reg[31:8]};
            end
            if (state == WRITE) word_idx <= idx_inc;
        end
    end

    // All outputs decode from state, so CORE_RESET_N follows RESET_N without a clock edge.
    assign BYTE_READY   = (state == LEN) || (state == DATA);
    assign IMEM_WE      = (state == WRITE);
    assign CORE_RESET_N = (state == RUN);
    assign DONE         = (state == RUN);
    assign ERROR        = (state == ERR);

    always_comb begin
        IMEM_ADDR  = '0;
        IMEM_WDATA = '0;
        if (state == WRITE) begin
            IMEM_ADDR  = 32'({word_idx, 2'b00});
            IMEM_WDATA = word_reg;
        end else if (state == RUN) begin
            IMEM_ADDR  = DIR_IMEM;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed corner sequences plus a randomized length table.
module tb_imem_loader;

    localparam int MAXW = 8;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  BYTE_IN = 8'h00;
    logic        BYTE_VALID = 1'b0;
    logic        BYTE_READY;
    logic [31:0] DIR_IMEM = 32'h55;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_WDATA;
    logic        IMEM_WE;
    logic        CORE_RESET_N;
    logic        DONE;
    logic        ERROR;

    int tests = 0;
    int fails = 0;
    logic [63:0] wq[$];

    imem_loader #(.MAX_WORDS(MAXW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .BYTE_IN(BYTE_IN),
        .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY), .DIR_IMEM(DIR_IMEM),
        .IMEM_ADDR(IMEM_ADDR), .IMEM_WDATA(IMEM_WDATA), .IMEM_WE(IMEM_WE),
        .CORE_RESET_N(CORE_RESET_N), .DONE(DONE), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (IMEM_WE === 1'b1) wq.push_back({IMEM_ADDR, IMEM_WDATA});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        repeat ($urandom_range(0, 1)) step();
        BYTE_IN    = b;
        BYTE_VALID = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = BYTE_READY;
            step();
        end
        BYTE_VALID = 1'b0;
        if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)));
    endtask

    task automatic wait_settle();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = DONE || ERROR;
            if (!ok) step();
        end
        if (!ok) chk("settle_timeout", 32'd0, 32'd1);
    endtask

    // Reference: word i of the program lands at byte address 4*i, in order, exactly once.
    task automatic check_writes(input string tag, input logic [31:0] words[$]);
        chk({tag, "_count"}, 32'(wq.size()), 32'(words.size()));
        for (int i = 0; i < words.size() && i < wq.size(); i++) begin
            chk({tag, "_addr"}, wq[i][63:32], 32'(4 * i));
            chk({tag, "_data"}, wq[i][31:0], words[i]);
        end
        wq.delete();
    endtask

    typedef struct {
        logic [31:0] n;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [31:0] words[$];
        logic [7:0]  q[$];
        int cyc;
        int lows;

        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words[$];
        logic [7:0]  q[$];
        int cyc;
        int lows;

        tbl[0] = '{32'd0,          1'b1, 1'b0};
        tbl[1] = '{32'd1,          1'b1, 1'b0};
        tbl[2] = '{32'd2,          1'b1, 1'b0};
        tbl[3] = '{32'(MAXW),      1'b1, 1'b0};
        tbl[4] = '{32'(MAXW + 1),  1'b0, 1'b1};
        tbl[5] = '{32'h0100_0001,  1'b0, 1'b1};

        // Reset state
        #12;
        chk("rst_core_reset_n", 32'(CORE_RESET_N), 32'd0);
        chk("rst_byte_ready",   32'(BYTE_READY),   32'd0);
        chk("rst_we",           32'(IMEM_WE),      32'd0);
        chk("rst_done",         32'(DONE),         32'd0);
        chk("rst_error",        32'(ERROR),        32'd0);
        chk("rst_addr",         IMEM_ADDR,         32'd0);
        chk("rst_wdata",        IMEM_WDATA,        32'd0);
        RESET_N = 1'b1;
        step();
        chk("idle_byte_ready", 32'(BYTE_READY), 32'd0);

        // Two-word reference program; START during LEN and DATA must be ignored
        pulse_start();
        chk("len_byte_ready", 32'(BYTE_READY), 32'd1);
        chk("len_addr_zero",  IMEM_ADDR,       32'd0);
        send_byte(8'h02); send_byte(8'h00);
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00);
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        wait_settle();
        chk("prog_done",         32'(DONE),         32'd1);
        chk("prog_core_reset_n", 32'(CORE_RESET_N), 32'd1);
        words = '{32'h0000_0013, 32'h0010_0093};
        check_writes("prog", words);

        // RUN pass-through and reload
        DIR_IMEM = 32'h8;
        #1;
        chk("run_addr_8", IMEM_ADDR, 32'h8);
        DIR_IMEM = 32'hDEAD_BEE4;
        #1;
        chk("run_addr_any", IMEM_ADDR, 32'hDEAD_BEE4);
        START = 1'b1;
        #1;
        chk("reload_same_cycle_core", 32'(CORE_RESET_N), 32'd1);
        step();
        START = 1'b0;
        chk("reload_core_reset_n", 32'(CORE_RESET_N), 32'd0);
        chk("reload_done",         32'(DONE),         32'd0);
        chk("reload_in_len",       32'(BYTE_READY),   32'd1);
        chk("reload_addr_zero",    IMEM_ADDR,         32'd0);

        // Zero-length program goes straight to RUN
        send_word(32'd0);
        chk("n0_done", 32'(DONE), 32'd1);
        words = {};
        check_writes("n0", words);

        // Asynchronous reset out of RUN
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_core_reset_n", 32'(CORE_RESET_N), 32'd0);
        chk("async_done",         32'(DONE),         32'd0);
        step();
        RESET_N = 1'b1;
        step();

        // Reset after 6 DATA bytes discards the partial load
        pulse_start();
        send_word(32'd2);
        send_word(32'hAAAA_0001);
        send_byte(8'h11); send_byte(8'h22);
        RESET_N = 1'b0;
        #1;
        chk("midload_byte_ready", 32'(BYTE_READY), 32'd0);
        step();
        RESET_N = 1'b1;
        step();
        wq.delete();
        chk("midload_idle", 32'(BYTE_READY), 32'd0);
        pulse_start();
        send_word(32'd1);
        send_word(32'hC0DE_0042);
        wait_settle();
        chk("midload_done", 32'(DONE), 32'd1);
        words = '{32'hC0DE_0042};
        check_writes("midload", words);

        // Streaming with BYTE_VALID held high: 4 length cycles then 5 cycles per word
        pulse_start();
        words = '{$urandom, $urandom, $urandom};
        q = {};
        for (int i = 0; i < 4; i++) q.push_back(8'(32'd3 >> (8 * i)));
        foreach (words[w]) for (int i = 0; i < 4; i++) q.push_back(8'(words[w] >> (8 * i)));
        cyc = 0;
        lows = 0;
        BYTE_VALID = 1'b1;
        for (int i = 0; i < 60 && !DONE; i++) begin
            BYTE_IN = (q.size() > 0) ? q[0] : 8'hEE;
            if (!BYTE_READY) lows++;
            if (BYTE_READY && q.size() > 0) void'(q.pop_front());
            cyc++;
            step();
        end
        BYTE_VALID = 1'b0;
        chk("stream_cycles",     32'(cyc),  32'd19);
        chk("stream_ready_lows", 32'(lows), 32'd3);
        chk("stream_done",       32'(DONE), 32'd1);
        check_writes("stream", words);

        // Randomized table of lengths, including capacity and overflow boundaries
        foreach (tbl[t]) begin
            pulse_start();
            words = {};
            if (tbl[t].n <= 32'(MAXW))
                for (int i = 0; i < int'(tbl[t].n); i++) words.push_back($urandom);
            send_word(tbl[t].n);
            foreach (words[i]) send_word(words[i]);
            wait_settle();
            chk("tbl_done",         32'(DONE),         32'(tbl[t].exp_done));
            chk("tbl_error",        32'(ERROR),        32'(tbl[t].exp_err));
            chk("tbl_core_reset_n", 32'(CORE_RESET_N), 32'(tbl[t].exp_done));
            chk("tbl_byte_ready",   32'(BYTE_READY),   32'd0);
            check_writes("tbl", words);
        end

        // START clears ERROR and re-enters LEN
        chk("err_held", 32'(ERROR), 32'd1);
        pulse_start();
        chk("err_cleared",     32'(ERROR),        32'd0);
        chk("err_len_ready",   32'(BYTE_READY),   32'd1);
        chk("err_core_reset",  32'(CORE_RESET_N), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
